// File: rtl/vga_timing_generator.sv
// vga_timing_generator: raster counters with registered sync and blanked colour, one pixel behind rows/columns.
// Define PIXEL_DIV2_EN to advance every second clk (clk at 2x the pixel rate).
module vga_timing_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] columns,
  output logic [9:0] rows,
  input  logic [3:0] data_red,
  input  logic [3:0] data_green,
  input  logic [3:0] data_blue,
  output logic [3:0] vga_red,
  output logic [3:0] vga_green,
  output logic [3:0] vga_blue,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  logic pix_en, disp, h_end;
`ifdef PIXEL_DIV2_EN
  logic pix_tog;
  always_ff @(posedge clk) pix_tog <= rst ? 1'b0 : ~pix_tog;
  assign pix_en = pix_tog;
`else
  assign pix_en = 1'b1;
`endif
  assign h_end = columns == H_LAST;
  assign disp = columns < HA && rows < VA;
  assign frame_start = columns == '0 && rows == '0;
  always_ff @(posedge clk)
    if (rst) begin
      columns   <= '0;
      rows      <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      video_on  <= 1'b0;
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
    end else if (pix_en) begin
      columns   <= h_end ? '0 : columns + 10'd1;
      if (h_end) rows <= rows == V_LAST ? '0 : rows + 10'd1;
      video_on  <= disp;
      vga_red   <= disp ? data_red : '0;
      vga_green <= disp ? data_green : '0;
      vga_blue  <= disp ? data_blue : '0;
      hsync     <= !(columns >= HS0 && columns < HS1);
      vsync     <= !(rows >= VS0 && rows < VS1);
    end
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: scoreboard bench; full-size instance for line timing, reduced instance for frame timing.
module tb_vga_timing_generator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic [3:0] dr = '0, dg = '0, db = '0;
  logic [9:0] col_a, row_a, col_b, row_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic hs_a, vs_a, vo_a, fs_a, hs_b, vs_b, vo_b, fs_b;
  logic [14:0] out_a, out_b;
  assign out_a = {vo_a, hs_a, vs_a, r_a, g_a, b_a};
  assign out_b = {vo_b, hs_b, vs_b, r_b, g_b, b_b};

  vga_timing_generator dut_a (
    .clk(clk), .rst(rst_a), .columns(col_a), .rows(row_a),
    .data_red(dr), .data_green(dg), .data_blue(db),
    .vga_red(r_a), .vga_green(g_a), .vga_blue(b_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .frame_start(fs_a)
  );

  vga_timing_generator #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_b (
    .clk(clk), .rst(rst_b), .columns(col_b), .rows(row_b),
    .data_red(dr), .data_green(dg), .data_blue(db),
    .vga_red(r_b), .vga_green(g_b), .vga_blue(b_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .frame_start(fs_b)
  );

  int ha, hf, hs, hb, va, vf, vs, vb, ht, vt;
  int mc, mr;
  int hs_run, vs_run, fs_cnt;
  bit fs_valid;
  logic [14:0] q[$];
  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (col=%0d row=%0d)", tag, got, exp, mc, mr);
    end
  endtask

  function automatic logic [14:0] expv(int c, int r, logic [3:0] cr, logic [3:0] cg, logic [3:0] cb);
    logic d, h, v;
    d = c < ha && r < va;
    h = !(c >= ha + hf && c < ha + hf + hs);
    v = !(r >= va + vf && r < va + vf + vs);
    return {d, h, v, d ? cr : 4'h0, d ? cg : 4'h0, d ? cb : 4'h0};
  endfunction

  task automatic set_geom(input int a, input int b, input int c, input int d,
                          input int e, input int f, input int g, input int h);
    ha = a; hf = b; hs = c; hb = d; va = e; vf = f; vs = g; vb = h;
    ht = a + b + c + d; vt = e + f + g + h;
    mc = 0; mr = 0; hs_run = 0; vs_run = 0; fs_cnt = 0; fs_valid = 0;
    q.delete();
  endtask

  // One pixel: compare what the DUT shows now, drive the plotter colour, queue the expected registered result.
  task automatic tick(input bit sel, input bit do_rst);
    logic [14:0] o, e;
    logic [9:0] c, r;
    logic fs;
    o = sel ? out_b : out_a;
    c = sel ? col_b : col_a;
    r = sel ? row_b : row_a;
    fs = sel ? fs_b : fs_a;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("video_on", o[14], e[14]);
      check("hsync", o[13], e[13]);
      check("vsync", o[12], e[12]);
      check("vga_red", o[11:8], e[11:8]);
      check("vga_green", o[7:4], e[7:4]);
      check("vga_blue", o[3:0], e[3:0]);
    end
    check("columns", c, mc);
    check("rows", r, mr);
    check("frame_start", fs, mc == 0 && mr == 0);
    if (!o[13]) hs_run++;
    else begin
      if (hs_run > 0) check("hsync_width", hs_run, hs);
      hs_run = 0;
    end
    if (!o[12]) vs_run++;
    else begin
      if (vs_run > 0) check("vsync_width", vs_run, vs * ht);
      vs_run = 0;
    end
    if (fs) begin
      if (fs_valid) check("frame_len", fs_cnt, ht * vt);
      fs_valid = 1;
      fs_cnt = 0;
    end
    fs_cnt++;
    if (sel) begin
      dr = 4'hF; dg = 4'hF; db = 4'hF;
      rst_b = do_rst;
    end else begin
      dr = 4'(mc); dg = ~4'(mc); db = 4'(mr);
      rst_a = do_rst;
    end
    q.push_back(do_rst ? 15'b011_0000_0000_0000 : expv(mc, mr, dr, dg, db));
    if (do_rst) begin
      hs_run = 0; vs_run = 0; fs_valid = 0;
    end
    @(posedge clk);
    if (do_rst) begin
      mc = 0; mr = 0;
    end else if (mc == ht - 1) begin
      mc = 0;
      mr = (mr == vt - 1) ? 0 : mr + 1;
    end else mc++;
    @(negedge clk);
    if (sel) rst_b = 1'b0;
    else rst_a = 1'b0;
  endtask

  initial begin
    bit did, rr;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_columns", col_a, 0);
    check("rst_rows", row_a, 0);
    check("rst_hsync", hs_a, 1);
    check("rst_vsync", vs_a, 1);
    check("rst_video_on", vo_a, 0);
    check("rst_vga", {r_a, g_a, b_a}, 0);
    rst_a = 1'b0;
    set_geom(640, 16, 96, 48, 480, 10, 2, 33);
    did = 0;
    for (int i = 0; i < 2600; i++) begin
      rr = !did && mr == 1 && mc == 300;
      tick(0, rr);
      if (rr) did = 1;
    end
    set_geom(16, 2, 4, 2, 8, 2, 2, 3);
    rst_b = 1'b0;
    did = 0;
    for (int i = 0; i < 1300; i++) begin
      rr = !did && i > 400 && mr == 5 && mc == 10;
      tick(1, rr);
      if (rr) did = 1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
